// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file command sequencer.
// Imported by the sequencer top and its datapath helper.
package regfile_pkg;

  localparam int W  = 16;
  localparam int AW = 3;

  typedef enum logic [1:0] {
    OP_MOVI,
    OP_ADD,
    OP_AND,
    OP_RDBK
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

endpackage

// File: rtl/regfile_sequencer_seq_alu.sv
// Write-data selector for the sequencer: add, and, or pass the
// immediate through, depending on the command opcode.
module seq_alu
  import regfile_pkg::*;
(
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] imm,
  output logic [W-1:0] y
);

  always_comb begin
    y = imm;
    unique case (op_t'(op))
      OP_ADD:  y = a + b;
      OP_AND:  y = a & b;
      default: y = imm;
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// Command-driven initiator for the 8x16 register file: MOVI, ADD,
// AND and read-back, one command at a time over valid/ready.
module regfile_sequencer
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rn,
  input  logic [AW-1:0] cmd_rm,
  input  logic [W-1:0]  cmd_imm,
  output logic          rf_write,
  output logic [AW-1:0] rf_reg_w,
  output logic [W-1:0]  rf_data_in,
  output logic [AW-1:0] rf_reg_a,
  output logic [AW-1:0] rf_reg_b,
  input  logic [W-1:0]  rf_out_a,
  input  logic [W-1:0]  rf_out_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [W-1:0]  rsp_data,
  output logic [15:0]   ops_done
);

  state_t        state, state_d;
  op_t           op_q, op_d;
  logic          write_d;
  logic [AW-1:0] reg_w_d;
  logic [AW-1:0] reg_a_d;
  logic [AW-1:0] reg_b_d;
  logic [W-1:0]  data_d;
  logic          rsp_valid_d;
  logic [W-1:0]  rsp_data_d;
  logic [15:0]   ops_d;
  logic [1:0]    alu_op;
  logic [W-1:0]  alu_y;

  assign cmd_ready = (state == S_IDLE) && !reset;

  // In idle the ALU sees the incoming opcode so MOVI can
  // register its write data on the accept edge.
  assign alu_op = (state == S_IDLE) ? cmd_op : op_q;

  seq_alu u_alu (
    .op  (alu_op),
    .a   (rf_out_a),
    .b   (rf_out_b),
    .imm (cmd_imm),
    .y   (alu_y)
  );

  always_comb begin
    state_d     = state;
    op_d        = op_q;
    write_d     = 1'b0;
    reg_w_d     = rf_reg_w;
    reg_a_d     = rf_reg_a;
    reg_b_d     = rf_reg_b;
    data_d      = rf_data_in;
    rsp_valid_d = rsp_valid;
    rsp_data_d  = rsp_data;
    ops_d       = ops_done;
    unique case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = op_t'(cmd_op);
          reg_w_d = cmd_rd;
          reg_a_d = cmd_rn;
          reg_b_d = cmd_rm;
          if (op_t'(cmd_op) == OP_MOVI) begin
            state_d = S_WRITE;
            write_d = 1'b1;
            data_d  = alu_y;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        if (op_q == OP_RDBK) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rf_out_a;
        end else begin
          state_d = S_WRITE;
          write_d = 1'b1;
          data_d  = alu_y;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
        ops_d   = ops_done + 16'd1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          ops_d       = ops_done + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= OP_MOVI;
      rf_write   <= 1'b0;
      rf_reg_w   <= '0;
      rf_reg_a   <= '0;
      rf_reg_b   <= '0;
      rf_data_in <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      ops_done   <= '0;
    end else begin
      state      <= state_d;
      op_q       <= op_d;
      rf_write   <= write_d;
      rf_reg_w   <= reg_w_d;
      rf_reg_a   <= reg_a_d;
      rf_reg_b   <= reg_b_d;
      rf_data_in <= data_d;
      rsp_valid  <= rsp_valid_d;
      rsp_data   <= rsp_data_d;
      ops_done   <= ops_d;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer with a negedge-write
// register file model attached to its rf_* ports.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_rd, cmd_rn, cmd_rm;
  logic [15:0] cmd_imm;
  logic        rf_write;
  logic [2:0]  rf_reg_w, rf_reg_a, rf_reg_b;
  logic [15:0] rf_data_in, rf_out_a, rf_out_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data, ops_done;

  logic [15:0] rf_m [8];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int wcount = 0;
  int wcyc = 0;
  int dbl = 0;
  int acc_cyc = 0;
  logic prev_w = 1'b0;

  regfile_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rn     (cmd_rn),
    .cmd_rm     (cmd_rm),
    .cmd_imm    (cmd_imm),
    .rf_write   (rf_write),
    .rf_reg_w   (rf_reg_w),
    .rf_data_in (rf_data_in),
    .rf_reg_a   (rf_reg_a),
    .rf_reg_b   (rf_reg_b),
    .rf_out_a   (rf_out_a),
    .rf_out_b   (rf_out_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  assign rf_out_a = rf_m[rf_reg_a];
  assign rf_out_b = rf_m[rf_reg_b];

  always @(posedge clk) cyc++;

  // Register file model: captures on the falling edge.
  always @(negedge clk) begin
    if (rf_write) begin
      rf_m[rf_reg_w] = rf_data_in;
      wcount++;
      wcyc = cyc;
      if (prev_w) dbl++;
    end
    prev_w = rf_write;
  end

  task automatic send(input logic [1:0] op, input logic [2:0] rd,
                      input logic [2:0] rn, input logic [2:0] rm,
                      input logic [15:0] imm);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!cmd_ready) begin
      bad++;
      $display("FAIL send_wait cmd_ready got=%0b want=1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rn    = rn;
    cmd_rm    = rm;
    cmd_imm   = imm;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic rdbk(input logic [2:0] r, output logic [15:0] d,
                      output bit ok);
    rsp_ready = 1'b1;
    send(2'd3, 3'd0, r, 3'd0, 16'h0);
    ok = 1'b0;
    d  = 16'h0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        d  = rsp_data;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++;
      $display("FAIL rst_ready got=%0b want=0", cmd_ready);
    end
    total++;
    if ({rf_write, rf_reg_w, rf_reg_a, rf_reg_b, rf_data_in,
         rsp_valid, rsp_data, ops_done} !== '0) begin
      bad++;
      $display("FAIL rst_outs got w=%0b d=%h v=%0b o=%h want zeros",
               rf_write, rf_data_in, rsp_valid, ops_done);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_release got=%0b want=1", cmd_ready);
    end
  endtask

  task automatic test_movi_rdbk;
    logic [15:0] d;
    bit ok;
    send(2'd0, 3'd3, 3'd0, 3'd0, 16'h1234);
    total++;
    if ({rf_write, rf_reg_w, rf_data_in} !== {1'b1, 3'd3, 16'h1234}) begin
      bad++;
      $display("FAIL movi_wr got w=%0b r=%0d d=%h want 1 3 1234",
               rf_write, rf_reg_w, rf_data_in);
    end
    @(posedge clk);
    #1;
    total++;
    if (rf_write !== 1'b0) begin
      bad++;
      $display("FAIL movi_pulse got=%0b want=0", rf_write);
    end
    rdbk(3'd3, d, ok);
    total++;
    if (!ok || d !== 16'h1234) begin
      bad++;
      $display("FAIL movi_rdbk got=%h ok=%0b want=1234", d, ok);
    end
    total++;
    if (ops_done !== 16'd2) begin
      bad++;
      $display("FAIL movi_ops got=%0d want=2", ops_done);
    end
  endtask

  task automatic test_add_carry;
    logic [15:0] d;
    bit ok;
    int a1, a2;
    send(2'd0, 3'd1, 3'd0, 3'd0, 16'hFFFF);
    a1 = acc_cyc;
    send(2'd0, 3'd2, 3'd0, 3'd0, 16'h0002);
    a2 = acc_cyc;
    total++;
    if (a2 - a1 !== 2) begin
      bad++;
      $display("FAIL movi_spacing got=%0d want=2", a2 - a1);
    end
    send(2'd1, 3'd4, 3'd1, 3'd2, 16'h0);
    total++;
    if ({rf_write, rf_reg_a, rf_reg_b} !== {1'b0, 3'd1, 3'd2}) begin
      bad++;
      $display("FAIL add_read got w=%0b a=%0d b=%0d want 0 1 2",
               rf_write, rf_reg_a, rf_reg_b);
    end
    @(posedge clk);
    #1;
    total++;
    if ({rf_write, rf_reg_w, rf_data_in} !== {1'b1, 3'd4, 16'h0001}) begin
      bad++;
      $display("FAIL add_wr got w=%0b r=%0d d=%h want 1 4 0001",
               rf_write, rf_reg_w, rf_data_in);
    end
    @(negedge clk);
    #1;
    total++;
    if (wcyc - acc_cyc + 1 !== 2) begin
      bad++;
      $display("FAIL add_latency got=%0d want=2", wcyc - acc_cyc + 1);
    end
    rdbk(3'd4, d, ok);
    total++;
    if (!ok || d !== 16'h0001) begin
      bad++;
      $display("FAIL add_rdbk got=%h ok=%0b want=0001", d, ok);
    end
    total++;
    if (ops_done !== 16'd6) begin
      bad++;
      $display("FAIL add_ops got=%0d want=6", ops_done);
    end
  endtask

  task automatic test_and_alias;
    logic [15:0] d;
    bit ok;
    send(2'd0, 3'd5, 3'd0, 3'd0, 16'h00F0);
    send(2'd0, 3'd6, 3'd0, 3'd0, 16'h0FF0);
    send(2'd2, 3'd5, 3'd5, 3'd6, 16'h0);
    @(posedge clk);
    #1;
    total++;
    if ({rf_write, rf_reg_w, rf_data_in} !== {1'b1, 3'd5, 16'h00F0}) begin
      bad++;
      $display("FAIL and_wr got w=%0b r=%0d d=%h want 1 5 00f0",
               rf_write, rf_reg_w, rf_data_in);
    end
    rdbk(3'd5, d, ok);
    total++;
    if (!ok || d !== 16'h00F0) begin
      bad++;
      $display("FAIL and_rdbk got=%h ok=%0b want=00f0", d, ok);
    end
  endtask

  task automatic test_rsp_stall;
    logic [15:0] o0;
    rsp_ready = 1'b0;
    o0 = ops_done;
    send(2'd3, 3'd0, 3'd3, 3'd0, 16'h0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp_valid, rsp_data, cmd_ready} !== {1'b1, 16'h1234, 1'b0}) begin
        bad++;
        $display("FAIL stall_hold%0d got v=%0b d=%h rdy=%0b want 1 1234 0",
                 i, rsp_valid, rsp_data, cmd_ready);
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({rsp_valid, cmd_ready, ops_done} !== {1'b0, 1'b1, o0 + 16'd1}) begin
      bad++;
      $display("FAIL stall_accept got v=%0b rdy=%0b o=%0d want 0 1 %0d",
               rsp_valid, cmd_ready, ops_done, o0 + 16'd1);
    end
  endtask

  task automatic test_reset_mid;
    logic [15:0] d;
    bit ok;
    int w0;
    send(2'd0, 3'd7, 3'd0, 3'd0, 16'hABCD);
    w0 = wcount + 1;
    send(2'd1, 3'd7, 3'd1, 3'd2, 16'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if ({rf_write, rf_reg_w, rf_reg_a, rf_reg_b, rf_data_in,
         rsp_valid, rsp_data, ops_done, cmd_ready} !== '0) begin
      bad++;
      $display("FAIL midrst_outs got w=%0b a=%0d d=%h o=%h rdy=%0b want 0",
               rf_write, rf_reg_a, rf_data_in, ops_done, cmd_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL midrst_ready got=%0b want=1", cmd_ready);
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (wcount !== w0) begin
      bad++;
      $display("FAIL midrst_nowrite got=%0d want=%0d", wcount, w0);
    end
    rdbk(3'd7, d, ok);
    total++;
    if (!ok || d !== 16'hABCD) begin
      bad++;
      $display("FAIL midrst_keep got=%h ok=%0b want=abcd", d, ok);
    end
  endtask

  task automatic test_wrap;
    logic [15:0] o0;
    o0 = ops_done;
    for (int i = 0; i < 300; i++) send(2'd0, 3'd0, 3'd0, 3'd0, 16'(i));
    @(posedge clk);
    #1;
    total++;
    if (ops_done !== o0 + 16'd300) begin
      bad++;
      $display("FAIL count300 got=%0d want=%0d", ops_done, o0 + 16'd300);
    end
    @(negedge clk);
    force dut.ops_done = 16'hFFFE;
    #1;
    release dut.ops_done;
    send(2'd0, 3'd0, 3'd0, 3'd0, 16'h1);
    send(2'd0, 3'd0, 3'd0, 3'd0, 16'h2);
    @(posedge clk);
    #1;
    total++;
    if (ops_done !== 16'h0000) begin
      bad++;
      $display("FAIL wrap got=%h want=0000", ops_done);
    end
    send(2'd0, 3'd0, 3'd0, 3'd0, 16'h3);
    @(posedge clk);
    #1;
    total++;
    if (ops_done !== 16'h0001) begin
      bad++;
      $display("FAIL wrap_next got=%h want=0001", ops_done);
    end
    total++;
    if (dbl !== 0) begin
      bad++;
      $display("FAIL double_write got=%0d want=0", dbl);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf_m[i] = 16'h0;
    cmd_op  = 2'd0;
    cmd_rd  = 3'd0;
    cmd_rn  = 3'd0;
    cmd_rm  = 3'd0;
    cmd_imm = 16'h0;
    test_reset();
    test_movi_rdbk();
    test_add_carry();
    test_and_alias();
    test_rsp_stall();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
